// File: rtl/layer_sequencer.sv
// Layer sequencer: splits one layer into filter-group x channel-group tiles,
// launches each on the PE array and pulses done_layer once at the end.
module layer_sequencer #(
  parameter int unsigned OFM_RAM_SIZE = 2378675,
  parameter int unsigned ADDR_W       = $clog2(OFM_RAM_SIZE),
  parameter int unsigned NUM_PE       = 16,
  parameter int unsigned CH_PER_TILE  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_layer,
  input  logic [8:0]        ifm_size,
  input  logic [10:0]       ifm_channel,
  input  logic [1:0]        kernel_size,
  input  logic [10:0]       num_filter,
  input  logic              maxpool_mode,
  input  logic [1:0]        maxpool_stride,
  input  logic              upsample_mode,
  input  logic [ADDR_W-1:0] start_read_addr,
  input  logic [ADDR_W-1:0] start_write_addr,
  input  logic              tile_done,
  output logic              tile_start,
  output logic [10:0]       tile_filter_base,
  output logic [4:0]        tile_num_filter,
  output logic [10:0]       tile_channel_base,
  output logic [4:0]        tile_num_channel,
  output logic              tile_first_ch,
  output logic              tile_last_ch,
  output logic [ADDR_W-1:0] tile_read_addr,
  output logic [ADDR_W-1:0] tile_write_addr,
  output logic [1:0]        tile_kernel_size,
  output logic [9:0]        ofm_size,
  output logic              busy,
  output logic              done_layer
);

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StNext, StDone} state_e;

  localparam logic [11:0] ChStep   = 12'(CH_PER_TILE);
  localparam logic [11:0] FiltStep = 12'(NUM_PE);

  state_e            state_q, state_d;
  logic [8:0]        ifm_size_q, ifm_size_d;
  logic [10:0]       ifm_channel_q, ifm_channel_d;
  logic [1:0]        kernel_size_q, kernel_size_d;
  logic [10:0]       num_filter_q, num_filter_d;
  logic              maxpool_mode_q, maxpool_mode_d;
  logic [1:0]        maxpool_stride_q, maxpool_stride_d;
  logic              upsample_mode_q, upsample_mode_d;
  logic [ADDR_W-1:0] start_read_addr_q, start_read_addr_d;
  logic [ADDR_W-1:0] start_write_addr_q, start_write_addr_d;
  logic [17:0]       ip_q, ip_d;
  logic [19:0]       op_q, op_d;
  logic [9:0]        ofm_size_q, ofm_size_d;
  logic [10:0]       fcnt_q, fcnt_d;
  logic [10:0]       ccnt_q, ccnt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic              tile_start_q, tile_start_d;
  logic [4:0]        tile_num_filter_q, tile_num_filter_d;
  logic [4:0]        tile_num_channel_q, tile_num_channel_d;
  logic              tile_first_ch_q, tile_first_ch_d;
  logic              tile_last_ch_q, tile_last_ch_d;
  logic              busy_q, busy_d;
  logic              done_layer_q, done_layer_d;

  logic [9:0]        ofm_calc;
  logic [11:0]       ch_next, f_next, f_rem, c_rem;
  logic              more_ch, more_f;
  logic [ADDR_W-1:0] rd_step, wr_step;

  always_comb begin
    if (upsample_mode_q) begin
      ofm_calc = {ifm_size_q, 1'b0};
    end else if (maxpool_mode_q && maxpool_stride_q == 2'd2) begin
      ofm_calc = {2'b00, ifm_size_q[8:1]};
    end else begin
      ofm_calc = {1'b0, ifm_size_q};
    end
  end

  // 12-bit sums so ccnt/fcnt + step cannot wrap near the 11-bit limit
  assign ch_next = {1'b0, ccnt_q} + ChStep;
  assign f_next  = {1'b0, fcnt_q} + FiltStep;
  assign more_ch = ch_next < {1'b0, ifm_channel_q};
  assign more_f  = f_next < {1'b0, num_filter_q};
  assign rd_step = ADDR_W'(ip_q) * ADDR_W'(CH_PER_TILE);
  assign wr_step = ADDR_W'(op_q) * ADDR_W'(NUM_PE);

  always_comb begin
    state_d            = state_q;
    ifm_size_d         = ifm_size_q;
    ifm_channel_d      = ifm_channel_q;
    kernel_size_d      = kernel_size_q;
    num_filter_d       = num_filter_q;
    maxpool_mode_d     = maxpool_mode_q;
    maxpool_stride_d   = maxpool_stride_q;
    upsample_mode_d    = upsample_mode_q;
    start_read_addr_d  = start_read_addr_q;
    start_write_addr_d = start_write_addr_q;
    ip_d               = ip_q;
    op_d               = op_q;
    ofm_size_d         = ofm_size_q;
    fcnt_d             = fcnt_q;
    ccnt_d             = ccnt_q;
    rd_d               = rd_q;
    wr_d               = wr_q;
    tile_num_filter_d  = tile_num_filter_q;
    tile_num_channel_d = tile_num_channel_q;
    tile_first_ch_d    = tile_first_ch_q;
    tile_last_ch_d     = tile_last_ch_q;
    f_rem              = '0;
    c_rem              = '0;

    unique case (state_q)
      StIdle: begin
        if (start_layer) begin
          ifm_size_d         = ifm_size;
          ifm_channel_d      = ifm_channel;
          kernel_size_d      = kernel_size;
          num_filter_d       = num_filter;
          maxpool_mode_d     = maxpool_mode;
          maxpool_stride_d   = maxpool_stride;
          upsample_mode_d    = upsample_mode;
          start_read_addr_d  = start_read_addr;
          start_write_addr_d = start_write_addr;
          state_d            = StLoad;
        end
      end
      StLoad: begin
        ip_d       = 18'(ifm_size_q) * 18'(ifm_size_q);
        ofm_size_d = ofm_calc;
        op_d       = 20'(ofm_calc) * 20'(ofm_calc);
        fcnt_d     = '0;
        ccnt_d     = '0;
        rd_d       = start_read_addr_q;
        wr_d       = start_write_addr_q;
        state_d    = (num_filter_q == '0 || ifm_channel_q == '0) ? StDone : StIssue;
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (tile_done) state_d = StNext;
      end
      StNext: begin
        if (more_ch) begin
          ccnt_d  = ch_next[10:0];
          rd_d    = rd_q + rd_step;
          state_d = StIssue;
        end else if (more_f) begin
          fcnt_d  = f_next[10:0];
          ccnt_d  = '0;
          rd_d    = start_read_addr_q;
          wr_d    = wr_q + wr_step;
          state_d = StIssue;
        end else begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Tile descriptor is captured on entry to ISSUE and held until the next one
    if (state_d == StIssue) begin
      f_rem              = {1'b0, num_filter_q} - {1'b0, fcnt_d};
      c_rem              = {1'b0, ifm_channel_q} - {1'b0, ccnt_d};
      tile_num_filter_d  = (f_rem >= FiltStep) ? 5'(NUM_PE) : f_rem[4:0];
      tile_num_channel_d = (c_rem >= ChStep) ? 5'(CH_PER_TILE) : c_rem[4:0];
      tile_first_ch_d    = (ccnt_d == '0);
      tile_last_ch_d     = ({1'b0, ccnt_d} + ChStep) >= {1'b0, ifm_channel_q};
    end
    tile_start_d = (state_d == StIssue);
    busy_d       = (state_d != StIdle);
    done_layer_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      ifm_size_q         <= '0;
      ifm_channel_q      <= '0;
      kernel_size_q      <= '0;
      num_filter_q       <= '0;
      maxpool_mode_q     <= 1'b0;
      maxpool_stride_q   <= '0;
      upsample_mode_q    <= 1'b0;
      start_read_addr_q  <= '0;
      start_write_addr_q <= '0;
      ip_q               <= '0;
      op_q               <= '0;
      ofm_size_q         <= '0;
      fcnt_q             <= '0;
      ccnt_q             <= '0;
      rd_q               <= '0;
      wr_q               <= '0;
      tile_start_q       <= 1'b0;
      tile_num_filter_q  <= '0;
      tile_num_channel_q <= '0;
      tile_first_ch_q    <= 1'b0;
      tile_last_ch_q     <= 1'b0;
      busy_q             <= 1'b0;
      done_layer_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      ifm_size_q         <= ifm_size_d;
      ifm_channel_q      <= ifm_channel_d;
      kernel_size_q      <= kernel_size_d;
      num_filter_q       <= num_filter_d;
      maxpool_mode_q     <= maxpool_mode_d;
      maxpool_stride_q   <= maxpool_stride_d;
      upsample_mode_q    <= upsample_mode_d;
      start_read_addr_q  <= start_read_addr_d;
      start_write_addr_q <= start_write_addr_d;
      ip_q               <= ip_d;
      op_q               <= op_d;
      ofm_size_q         <= ofm_size_d;
      fcnt_q             <= fcnt_d;
      ccnt_q             <= ccnt_d;
      rd_q               <= rd_d;
      wr_q               <= wr_d;
      tile_start_q       <= tile_start_d;
      tile_num_filter_q  <= tile_num_filter_d;
      tile_num_channel_q <= tile_num_channel_d;
      tile_first_ch_q    <= tile_first_ch_d;
      tile_last_ch_q     <= tile_last_ch_d;
      busy_q             <= busy_d;
      done_layer_q       <= done_layer_d;
    end
  end

  assign tile_start        = tile_start_q;
  assign tile_filter_base  = fcnt_q;
  assign tile_num_filter   = tile_num_filter_q;
  assign tile_channel_base = ccnt_q;
  assign tile_num_channel  = tile_num_channel_q;
  assign tile_first_ch     = tile_first_ch_q;
  assign tile_last_ch      = tile_last_ch_q;
  assign tile_read_addr    = rd_q;
  assign tile_write_addr   = wr_q;
  assign tile_kernel_size  = kernel_size_q;
  assign ofm_size          = ofm_size_q;
  assign busy              = busy_q;
  assign done_layer        = done_layer_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: tile order, addresses, latency, abort by reset.
module tb_layer_sequencer;

  localparam int unsigned AW = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_layer = 1'b0;
  logic [8:0]    ifm_size = '0;
  logic [10:0]   ifm_channel = '0;
  logic [1:0]    kernel_size = '0;
  logic [10:0]   num_filter = '0;
  logic          maxpool_mode = 1'b0;
  logic [1:0]    maxpool_stride = '0;
  logic          upsample_mode = 1'b0;
  logic [AW-1:0] start_read_addr = '0;
  logic [AW-1:0] start_write_addr = '0;
  logic          tile_done = 1'b0;
  logic          tile_start;
  logic [10:0]   tile_filter_base;
  logic [4:0]    tile_num_filter;
  logic [10:0]   tile_channel_base;
  logic [4:0]    tile_num_channel;
  logic          tile_first_ch;
  logic          tile_last_ch;
  logic [AW-1:0] tile_read_addr;
  logic [AW-1:0] tile_write_addr;
  logic [1:0]    tile_kernel_size;
  logic [9:0]    ofm_size;
  logic          busy;
  logic          done_layer;

  int checks = 0;
  int failures = 0;

  layer_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_layer      (start_layer),
    .ifm_size         (ifm_size),
    .ifm_channel      (ifm_channel),
    .kernel_size      (kernel_size),
    .num_filter       (num_filter),
    .maxpool_mode     (maxpool_mode),
    .maxpool_stride   (maxpool_stride),
    .upsample_mode    (upsample_mode),
    .start_read_addr  (start_read_addr),
    .start_write_addr (start_write_addr),
    .tile_done        (tile_done),
    .tile_start       (tile_start),
    .tile_filter_base (tile_filter_base),
    .tile_num_filter  (tile_num_filter),
    .tile_channel_base(tile_channel_base),
    .tile_num_channel (tile_num_channel),
    .tile_first_ch    (tile_first_ch),
    .tile_last_ch     (tile_last_ch),
    .tile_read_addr   (tile_read_addr),
    .tile_write_addr  (tile_write_addr),
    .tile_kernel_size (tile_kernel_size),
    .ofm_size         (ofm_size),
    .busy             (busy),
    .done_layer       (done_layer)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int sz, input int ch, input int k, input int nf, input bit mp,
                         input int mps, input bit up, input int rb, input int wb);
    ifm_size         = 9'(sz);
    ifm_channel      = 11'(ch);
    kernel_size      = 2'(k);
    num_filter       = 11'(nf);
    maxpool_mode     = mp;
    maxpool_stride   = 2'(mps);
    upsample_mode    = up;
    start_read_addr  = AW'(rb);
    start_write_addr = AW'(wb);
  endtask

  // Bounded wait for tile_start; returns number of extra cycles waited.
  task automatic wait_start(output int n);
    n = 0;
    while (tile_start !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
  endtask

  task automatic run_layer(input string tag, input int nch, input int nf, input int rb,
                           input int wb, input int rstep, input int wstep, input int k,
                           input int ofm, input bit poke);
    int nfg, ncg, n, starts, rem;
    logic [AW-1:0] exp_rd, exp_wr;
    nfg = (nf + 15) / 16;
    ncg = (nch + 15) / 16;
    starts = 0;
    start_layer = 1'b1;
    tick();
    start_layer = 1'b0;
    tick();
    for (int fg = 0; fg < nfg; fg++) begin
      for (int cg = 0; cg < ncg; cg++) begin
        wait_start(n);
        chk({tag, "_latency"}, 32'(n), 32'd0);
        if (tile_start === 1'b1) starts++;
        exp_rd = AW'(rb + cg * rstep);
        exp_wr = AW'(wb + fg * wstep);
        chk({tag, "_fbase"}, 32'(tile_filter_base), 32'(fg * 16));
        chk({tag, "_cbase"}, 32'(tile_channel_base), 32'(cg * 16));
        chk({tag, "_rd"}, 32'(tile_read_addr), 32'(exp_rd));
        chk({tag, "_wr"}, 32'(tile_write_addr), 32'(exp_wr));
        rem = nf - fg * 16;
        chk({tag, "_nfilt"}, 32'(tile_num_filter), 32'((rem >= 16) ? 16 : rem));
        rem = nch - cg * 16;
        chk({tag, "_nch"}, 32'(tile_num_channel), 32'((rem >= 16) ? 16 : rem));
        chk({tag, "_first"}, 32'(tile_first_ch), 32'(cg == 0));
        chk({tag, "_last"}, 32'(tile_last_ch), 32'(cg == ncg - 1));
        chk({tag, "_kernel"}, 32'(tile_kernel_size), 32'(k));
        chk({tag, "_ofm"}, 32'(ofm_size), 32'(ofm));
        tick();
        chk({tag, "_start_width"}, 32'(tile_start), 32'd0);
        if (poke && fg == 0 && cg == 0) begin
          start_layer = 1'b1;
          tick();
          start_layer = 1'b0;
          chk({tag, "_poke_start"}, 32'(tile_start), 32'd0);
        end
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        tick();
      end
    end
    chk({tag, "_starts"}, 32'(starts), 32'(nfg * ncg));
    chk({tag, "_done"}, 32'(done_layer), 32'd1);
    chk({tag, "_done_start"}, 32'(tile_start), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done_width"}, 32'(done_layer), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tile_start"}, 32'(tile_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done_layer), 32'd0);
    chk({tag, "_fbase"}, 32'(tile_filter_base), 32'd0);
    chk({tag, "_cbase"}, 32'(tile_channel_base), 32'd0);
    chk({tag, "_nfilt"}, 32'(tile_num_filter), 32'd0);
    chk({tag, "_nch"}, 32'(tile_num_channel), 32'd0);
    chk({tag, "_first"}, 32'(tile_first_ch), 32'd0);
    chk({tag, "_last"}, 32'(tile_last_ch), 32'd0);
    chk({tag, "_rd"}, 32'(tile_read_addr), 32'd0);
    chk({tag, "_wr"}, 32'(tile_write_addr), 32'd0);
    chk({tag, "_kernel"}, 32'(tile_kernel_size), 32'd0);
    chk({tag, "_ofm"}, 32'(ofm_size), 32'd0);
  endtask

  initial begin
    int extra, n, dones;

    // Reset state
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // 54x54, 16ch, 16f, k3, maxpool stride 2: a single tile
    set_cfg(54, 16, 3, 16, 1'b1, 2, 1'b0, 0, 0);
    start_layer = 1'b1;
    tick();
    start_layer = 1'b0;
    set_cfg(7, 200, 1, 0, 1'b0, 1, 1'b1, 99, 99);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_start", 32'(tile_start), 32'd0);
    tick();
    chk("t1_c2_start", 32'(tile_start), 32'd1);
    chk("t1_fbase", 32'(tile_filter_base), 32'd0);
    chk("t1_cbase", 32'(tile_channel_base), 32'd0);
    chk("t1_nfilt", 32'(tile_num_filter), 32'd16);
    chk("t1_nch", 32'(tile_num_channel), 32'd16);
    chk("t1_first", 32'(tile_first_ch), 32'd1);
    chk("t1_last", 32'(tile_last_ch), 32'd1);
    chk("t1_ofm", 32'(ofm_size), 32'd27);
    chk("t1_kernel", 32'(tile_kernel_size), 32'd3);
    chk("t1_rd", 32'(tile_read_addr), 32'd0);
    extra = 0;
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (tile_start === 1'b1) extra++;
    end
    chk("t1_single_tile", 32'(extra), 32'd0);
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("t1_c11_done", 32'(done_layer), 32'd0);
    tick();
    chk("t1_c12_done", 32'(done_layer), 32'd1);
    chk("t1_c12_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_c13_done", 32'(done_layer), 32'd0);
    chk("t1_c13_busy", 32'(busy), 32'd0);
    tick();

    // 13x13, 512ch, 255f, k1: 16 filter groups x 32 channel groups
    set_cfg(13, 512, 1, 255, 1'b0, 1, 1'b0, 1644032, 1730560);
    run_layer("t2", 512, 255, 1644032, 1730560, 2704, 2704, 1, 13, 1'b0);
    tick();

    // Upsample 13 -> 26, 256ch, 128f
    set_cfg(13, 256, 3, 128, 1'b0, 1, 1'b1, 100, 5000);
    run_layer("t3", 256, 128, 100, 5000, 2704, 10816, 3, 26, 1'b0);
    tick();

    // Zero filters: no tile, done at cycle 2
    set_cfg(13, 32, 1, 0, 1'b0, 1, 1'b0, 0, 0);
    start_layer = 1'b1;
    tick();
    start_layer = 1'b0;
    chk("t4_c1_start", 32'(tile_start), 32'd0);
    chk("t4_c1_done", 32'(done_layer), 32'd0);
    tick();
    chk("t4_c2_start", 32'(tile_start), 32'd0);
    chk("t4_c2_done", 32'(done_layer), 32'd1);
    tick();
    chk("t4_c3_done", 32'(done_layer), 32'd0);
    chk("t4_c3_busy", 32'(busy), 32'd0);
    tick();

    // Partial groups 20ch/20f, with a start_layer poke during WAIT
    set_cfg(10, 20, 1, 20, 1'b0, 1, 1'b0, 0, 0);
    run_layer("t5", 20, 20, 0, 0, 1600, 1600, 1, 10, 1'b1);
    tick();

    // Abort by reset during WAIT of the third tile
    start_layer = 1'b1;
    tick();
    start_layer = 1'b0;
    tick();
    for (int t = 0; t < 3; t++) begin
      wait_start(n);
      chk("t6_latency", 32'(n), 32'd0);
      tick();
      if (t < 2) begin
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        tick();
      end
    end
    chk("t6_pre_fbase", 32'(tile_filter_base), 32'd16);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_abort");
    tick();
    rst_n = 1'b1;
    tick();
    run_layer("t6_rerun", 20, 20, 0, 0, 1600, 1600, 1, 10, 1'b0);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done_layer === 1'b1) dones++;
    end
    chk("t6_no_extra_done", 32'(dones), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Layer-side counterpart of the network-level controller: accepts one start_layer pulse plus the layer configuration and runs the layer to completion.
- Splits the layer into filter-group × channel-group tiles, issues each tile to the PE-array compute engine via a tile_start/tile_done handshake, and tracks IFM read and OFM write base addresses.
- Returns exactly one single-cycle done_layer pulse per layer; the upstream layer counter advances on its falling edge.

Parameters:
- OFM_RAM_SIZE, 2378675, feature-map RAM depth; ADDR_W = $clog2(OFM_RAM_SIZE) = 22.
- NUM_PE, 16, filters computed per tile.
- CH_PER_TILE, 16, input channels accumulated per tile.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_layer  in  1  one-cycle layer start pulse
- ifm_size  in  9  input feature-map width/height
- ifm_channel  in  11  input channel count
- kernel_size  in  2  1 or 3; passed through unchanged, latched
- num_filter  in  11  output filter count
- maxpool_mode  in  1  maxpool enable
- maxpool_stride  in  2  1 or 2
- upsample_mode  in  1  2x upsample enable
- start_read_addr  in  ADDR_W  IFM base address
- start_write_addr  in  ADDR_W  OFM base address
- tile_done  in  1  compute engine finished current tile (pulse)
- tile_start  out  1  one-cycle tile launch pulse
- tile_filter_base  out  11  first filter of tile
- tile_num_filter  out  5  filters in tile, 1..NUM_PE
- tile_channel_base  out  11  first channel of tile
- tile_num_channel  out  5  channels in tile, 1..CH_PER_TILE
- tile_first_ch  out  1  first channel group: clear accumulators
- tile_last_ch  out  1  last channel group: write OFM
- tile_read_addr  out  ADDR_W  IFM address of tile_channel_base plane
- tile_write_addr  out  ADDR_W  OFM address of tile_filter_base plane
- tile_kernel_size  out  2  latched kernel_size
- ofm_size  out  10  computed output size
- busy  out  1  high from LOAD through DONE
- done_layer  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and registers 0. Reset asserted mid-layer aborts immediately to IDLE. No done_layer is generated for the aborted layer.
- FSM states and transitions:
  - IDLE: start_layer → LOAD. Latch all config inputs on that edge.
  - LOAD (1 cycle):
    - Compute ip = ifm_size², 18 bits.
    - Compute ofm_size:
      - upsample_mode=1: ifm_size×2.
      - Else maxpool_mode=1 and maxpool_stride=2: ifm_size>>1.
      - Otherwise: ifm_size.
    - Compute op = ofm_size², 20 bits.
    - Clear fcnt/ccnt.
    - Set rd=start_read_addr, wr=start_write_addr.
    - If num_filter==0 or ifm_channel==0 → DONE; else → ISSUE.
  - ISSUE (1 cycle):
    - tile_start=1.
    - Tile outputs take their values from registers; they are stable from ISSUE until the next ISSUE.
    - Go to WAIT.
  - WAIT: hold until tile_done=1 → NEXT. tile_done is sampled only in WAIT; it is ignored in all other states.
  - NEXT:
    - If ccnt+CH_PER_TILE < ifm_channel: ccnt+=CH_PER_TILE, rd+=ip×CH_PER_TILE, then → ISSUE.
    - Else if fcnt+NUM_PE < num_filter: fcnt+=NUM_PE, ccnt=0, rd=start_read_addr, wr+=op×NUM_PE, then → ISSUE.
    - Else → DONE.
  - DONE (1 cycle): done_layer=1, then → IDLE.
- Loop order: filter group outer, channel group inner.
- Tile fields:
  - tile_num_filter = min(NUM_PE, num_filter−fcnt).
  - tile_num_channel = min(CH_PER_TILE, ifm_channel−ccnt).
  - tile_first_ch = (ccnt==0).
  - tile_last_ch = (ccnt+CH_PER_TILE ≥ ifm_channel).
- Address arithmetic is modulo 2^ADDR_W; products use ADDR_W-bit widths.
- Latency:
  - start_layer (cycle 0) → first tile_start at cycle 2.
  - tile_done (cycle t) → next tile_start at t+2.
  - Final tile_done (cycle t) → done_layer at t+2.
  - Zero-size layer: done_layer at cycle 2.
- start_layer while busy=1 is ignored and does not re-latch config.
- Config input changes after latching have no effect.
- busy falls in the cycle after done_layer.

Test Plan:
- Config 54/16ch/16f/k3/maxpool s2, read 0, write 0: exactly one tile_start at cycle 2 with base 0/0, nums 16/16, first=last=1, ofm_size=27. tile_done at cycle 10 → done_layer at cycle 12, pulse width 1.
- Config 13/512ch/255f/k1, read 1644032, write 1730560:
  - 512 tile_starts in total; filter group 0 tile_read_addr steps by 2704.
  - Group 1 has write 1733264, read reset to 1644032.
  - Group 15 has tile_num_filter=15.
  - tile_last_ch=1 only when tile_channel_base=496.
- Upsample config 13/256ch/128f: ofm_size=26. wr for group 1 = base + 676×16 = base+10816.
- num_filter=0: no tile_start; done_layer at cycle 2.
- Partial groups, 20ch/20f:
  - 4 tiles with (fbase,cbase) sequence (0,0), (0,16), (16,0), (16,16).
  - tile_num_channel/filter cycle 16,4.
  - start_layer pulsed during WAIT is ignored.
- rst_n low during WAIT of tile 3: all outputs 0 asynchronously. A subsequent start_layer restarts from tile 0, and only one done_layer follows.
